// File: rtl/ir_cmd_ctrl.sv
// ir_cmd_ctrl: validates decoded IR frames, drops repeats inside a holdoff
// window and queues accepted {addr,cmd} pairs in a small first-word
// fall-through FIFO for a downstream consumer.
module ir_cmd_ctrl #(
   parameter int         DEPTH       = 4,
   parameter int         HOLDOFF     = 11000000,
   parameter bit         FILTER_EN   = 1'b0,
   parameter logic [7:0] FILTER_ADDR = 8'h10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] burst,
   input  logic        burst_rdy,
   output logic        rcv_clr,
   output logic [7:0]  cmd_addr,
   output logic [7:0]  cmd_data,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [7:0]  err_cnt,
   output logic        ovf
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
   localparam logic [HW-1:0] HOLDOFF_V = HW'(HOLDOFF);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_PUSH  = 2'd2,
      S_ERR   = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_next;

   logic            r_rdy_d;
   logic [31:0]     r_burst;
   logic [15:0]     r_last;
   logic [HW-1:0]   r_hold;
   logic [7:0]      r_err_cnt;
   logic            r_ovf;
   logic [AW:0]     r_wptr;
   logic [AW:0]     r_rptr;
   logic [15:0]     r_mem [DEPTH];

   logic            w_edge;
   logic            w_chk_ok;
   logic            w_addr_ok;
   logic            w_dup;
   logic [15:0]     w_code;
   logic            w_empty;
   logic            w_full;
   logic            w_pop;
   logic            w_wr;
   logic            w_drop;
   logic [15:0]     w_head;

   // Frame qualification and FIFO status
   assign w_edge    = burst_rdy & ~r_rdy_d;
   assign w_code    = {r_burst[7:0], r_burst[23:16]};
   assign w_chk_ok  = (r_burst[15:8] == ~r_burst[7:0]) && (r_burst[31:24] == ~r_burst[23:16]);
   assign w_addr_ok = !FILTER_EN || (r_burst[7:0] == FILTER_ADDR);
   assign w_dup     = (w_code == r_last) && (r_hold != '0);

   assign w_empty   = (r_wptr == r_rptr);
   assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_pop     = !w_empty && cmd_ready;
   // A full FIFO still accepts the write when the head leaves in the same cycle
   assign w_wr      = (r_state == S_PUSH) && (!w_full || w_pop);
   assign w_drop    = (r_state == S_PUSH) && w_full && !w_pop;

   assign w_head    = r_mem[r_rptr[AW-1:0]];
   assign cmd_addr  = w_head[15:8];
   assign cmd_data  = w_head[7:0];
   assign cmd_valid = !w_empty;
   assign err_cnt   = r_err_cnt;
   assign ovf       = r_ovf;

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_next;
   end

   // FSM next state and the receiver resync pulse
   always_comb begin
      w_state_next = r_state;
      rcv_clr      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_edge) w_state_next = S_CHECK;
         end
         S_CHECK: begin
            if (!w_chk_ok || !w_addr_ok) w_state_next = S_ERR;
            else if (w_dup)              w_state_next = S_IDLE;
            else                         w_state_next = S_PUSH;
         end
         S_PUSH: begin
            w_state_next = S_IDLE;
         end
         S_ERR: begin
            rcv_clr      = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Edge detector and frame capture; busy-state edges are simply not captured
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rdy_d <= 1'b0;
         r_burst <= '0;
      end else begin
         r_rdy_d <= burst_rdy;
         if (r_state == S_IDLE && w_edge) r_burst <= burst;
      end
   end

   // Last accepted code and holdoff window; any accepted write restarts the window
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_last <= '0;
         r_hold <= '0;
      end else if (w_wr) begin
         r_last <= w_code;
         r_hold <= HOLDOFF_V;
      end else if (r_hold != '0) begin
         r_hold <= r_hold - HW'(1);
      end
   end

   // Error counter (saturating) and sticky overflow flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err_cnt <= '0;
         r_ovf     <= 1'b0;
      end else begin
         if (r_state == S_ERR && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
         if (w_drop) r_ovf <= 1'b1;
      end
   end

   // FIFO pointers with an extra wrap bit to tell full from empty
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_wr)  r_wptr <= r_wptr + (AW+1)'(1);
         if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
      end
   end

   // FIFO storage; contents need no reset since the pointers define validity
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr[AW-1:0]] <= w_code;
   end

endmodule

// File: tb/tb_ir_cmd_ctrl.sv
// tb_ir_cmd_ctrl: randomized and directed frames against a transaction-level
// model; a negedge monitor checks the FIFO head, flags and rcv_clr pulses.
module tb_ir_cmd_ctrl;

   localparam int DEPTH   = 4;
   localparam int HOLDOFF = 100;
   localparam int K_ERR   = 0;
   localparam int K_DUP   = 1;
   localparam int K_PUSH  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] burst = '0;
   logic        burst_rdy = 1'b0;
   logic        rcv_clr;
   logic [7:0]  cmd_addr;
   logic [7:0]  cmd_data;
   logic        cmd_valid;
   logic        cmd_ready = 1'b0;
   logic [7:0]  err_cnt;
   logic        ovf;

   ir_cmd_ctrl #(
      .DEPTH(DEPTH), .HOLDOFF(HOLDOFF), .FILTER_EN(1'b1), .FILTER_ADDR(8'h10)
   ) dut (
      .clk(clk), .rst(rst), .burst(burst), .burst_rdy(burst_rdy),
      .rcv_clr(rcv_clr), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .err_cnt(err_cnt), .ovf(ovf)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_pops = 0;

   // reference model state (timestamps in clock edges)
   longint      cyc = 0;
   logic [15:0] exp_q[$];
   int          m_occ;
   logic [15:0] last_code;
   longint      last_wr;
   longint      free_edge;
   bit          pend;
   longint      pend_e;
   int          pend_kind;
   logic [15:0] pend_code;
   int          m_err;
   bit          m_ovf;
   bit          exp_rcv;
   bit          prev_rdy;
   bit          rmode = 1'b0;
   int          rprob = 50;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c);
      return {~c, c, ~a, a};
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_occ = 0; last_code = '0; last_wr = -1000000; free_edge = 0;
      pend = 1'b0; m_err = 0; m_ovf = 1'b0; exp_rcv = 1'b0; prev_rdy = 1'b0;
   endtask

   // Apply the effects of the clock edge that just occurred
   task automatic model_edge();
      bit pop;
      bit wr;
      bit ok;
      logic [31:0] b;
      if (!rst) begin
         prev_rdy = 1'b0;
         cyc++;
         return;
      end
      pop = cmd_ready && (m_occ > 0);
      wr  = 1'b0;
      exp_rcv = 1'b0;
      if (pend) begin
         if (cyc == pend_e + 1 && pend_kind == K_ERR) exp_rcv = 1'b1;
         if (cyc == pend_e + 2) begin
            if (pend_kind == K_ERR) m_err = (m_err < 255) ? m_err + 1 : 255;
            else if (pend_kind == K_PUSH) begin
               if (m_occ < DEPTH || pop) begin
                  wr = 1'b1;
                  exp_q.push_back(pend_code);
                  last_code = pend_code;
                  last_wr   = cyc;
               end else m_ovf = 1'b1;
            end
            pend = 1'b0;
         end
      end
      m_occ = m_occ + int'(wr) - int'(pop);
      if (burst_rdy && !prev_rdy && cyc >= free_edge) begin
         b  = burst;
         ok = (b[15:8] == ~b[7:0]) && (b[31:24] == ~b[23:16]) && (b[7:0] == 8'h10);
         pend_code = {b[7:0], b[23:16]};
         if (!ok) pend_kind = K_ERR;
         else if (pend_code == last_code && (cyc - last_wr) < HOLDOFF) pend_kind = K_DUP;
         else pend_kind = K_PUSH;
         pend   = 1'b1;
         pend_e = cyc;
         free_edge = (pend_kind == K_DUP) ? cyc + 2 : cyc + 3;
      end
      prev_rdy = burst_rdy;
      cyc++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_edge();
      if (rmode) cmd_ready = ($urandom_range(0, 99) < rprob);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      burst_rdy = 1'b0;
      model_reset();
      repeat (3) tick();
      rst = 1'b1;
   endtask

   task automatic send(input logic [31:0] f, input int hold, input int gap);
      burst = f;
      burst_rdy = 1'b1;
      repeat (hold) tick();
      burst_rdy = 1'b0;
      repeat (gap) tick();
   endtask

   // Monitor: compares DUT outputs with the model every cycle, pops on handshake
   initial begin
      logic [15:0] e;
      forever begin
         @(negedge clk);
         chk("cmd_valid", int'(cmd_valid), int'(exp_q.size() > 0));
         chk("err_cnt", int'(err_cnt), m_err);
         chk("ovf", int'(ovf), int'(m_ovf));
         if (rcv_clr || exp_rcv) chk("rcv_clr", int'(rcv_clr), int'(exp_rcv));
         if (cmd_valid && cmd_ready && rst) begin
            if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("head", int'({cmd_addr, cmd_data}), int'(e));
               n_pops++;
            end
         end
      end
   end

   // Watchdog
   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: run exceeded cycle budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      logic [7:0] a;
      logic [7:0] c;
      logic [31:0] f;
      model_reset();
      repeat (2) tick();
      chk("reset_valid", int'(cmd_valid), 0);
      chk("reset_rcv_clr", int'(rcv_clr), 0);
      chk("reset_err", int'(err_cnt), 0);
      rst = 1'b1;
      tick();

      // single good frame, consumer ready
      cmd_ready = 1'b1;
      p0 = n_pops;
      send(32'h27D8EF10, 1, 8);
      chk("single_pops", n_pops - p0, 1);
      chk("single_err", int'(err_cnt), 0);

      // bad ~addr
      send(32'h27D8EF11, 1, 8);
      chk("bad_err", int'(err_cnt), 1);

      // holdoff window
      do_reset();
      cmd_ready = 1'b1;
      p0 = n_pops;
      send(32'h27D8EF10, 1, 49);
      send(32'h27D8EF10, 1, 199);
      send(32'h27D8EF10, 3, 10);
      chk("holdoff_entries", n_pops - p0, 2);

      // overflow with stalled consumer, then drain
      do_reset();
      cmd_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(mk(8'h10, 8'h60 + 8'(i)), 1, 4);
      chk("ovf_set", int'(ovf), 1);
      p0 = n_pops;
      cmd_ready = 1'b1;
      repeat (10) tick();
      chk("drain_pops", n_pops - p0, 4);

      // address filter
      send(mk(8'h20, 8'h33), 1, 6);
      chk("filter_err", int'(err_cnt), 1);

      // reset during CHECK, then during PUSH; the next frame is accepted
      do_reset();
      cmd_ready = 1'b1;
      send(mk(8'h10, 8'h55), 1, 0);
      burst_rdy = 1'b0;
      do_reset();
      send(mk(8'h10, 8'h56), 2, 0);
      burst_rdy = 1'b0;
      do_reset();
      p0 = n_pops;
      send(mk(8'h10, 8'h55), 1, 8);
      chk("post_reset_pops", n_pops - p0, 1);

      // saturation of the error counter
      for (int i = 0; i < 260; i++) send(32'h27D8EF11, 1, 3);
      chk("err_sat", int'(err_cnt), 255);

      // randomized traffic with random consumer stalls
      do_reset();
      rmode = 1'b1;
      for (int i = 0; i < 500; i++) begin
         if (i % 100 == 0) rprob = $urandom_range(10, 90);
         c = 8'h40 + 8'($urandom_range(0, 3));
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: f = mk(8'h10, c);
            6, 7: begin
               a = ($urandom_range(0, 1) == 0) ? 8'h10 : 8'($urandom);
               f = mk(a, 8'($urandom));
            end
            8: f = mk(8'h10, c) ^ 32'h0000_0100;
            default: f = mk(8'h10, c) ^ 32'h0100_0000;
         endcase
         send(f, $urandom_range(1, 3), $urandom_range(1, 6));
      end
      rmode = 1'b0;
      cmd_ready = 1'b1;
      repeat (20) tick();
      chk("final_empty", int'(exp_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
